// File: rtl/ads1115_pkg.sv
// ads1115_pkg: op and state encodings, ADS1115 register pointers and step indices
// shared by the ADS1115 continuous-mode sequencer.
package ads1115_pkg;

    typedef enum logic [2:0] {
        OP_START_W,
        OP_START_R,
        OP_W,
        OP_R_ACK,
        OP_R_NACK,
        OP_STOP
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ARMED,
        S_NACK,
        S_NACK_WAIT,
        S_RETRY
    } state_e;

    localparam logic [7:0] PTR_CONV      = 8'h00;
    localparam logic [7:0] PTR_CONFIG    = 8'h01;
    localparam logic [7:0] PTR_LO_THRESH = 8'h02;
    localparam logic [7:0] PTR_HI_THRESH = 8'h03;

    localparam logic [4:0] STEP_CFG_LAST = 5'd14;
    localparam logic [4:0] STEP_RD_FIRST = 5'd15;
    localparam logic [4:0] STEP_RD_LAST  = 5'd20;

    // Ops whose completion carries a slave ACK bit worth checking.
    function automatic logic expects_ack(input op_e op);
        return op inside {OP_START_W, OP_START_R, OP_W};
    endfunction

endpackage

// File: rtl/ads1115_op_rom.sv
// ads1115_op_rom: maps a sequencer step to the I2C master op and byte.
// Steps 0-14 program the thresholds and config, steps 15-20 read the conversion.
module ads1115_op_rom
    import ads1115_pkg::*;
#(
    parameter logic [15:0] CONFIG = 16'hC284
) (
    input  logic [4:0] step_i,
    output op_e        op_o,
    output logic [7:0] byte_o
);

    always_comb begin
        op_o   = OP_STOP;
        byte_o = 8'h00;
        case (step_i)
            5'd0, 5'd5, 5'd10, 5'd15: op_o = OP_START_W;
            5'd1:  begin op_o = OP_W; byte_o = PTR_LO_THRESH; end
            5'd6:  begin op_o = OP_W; byte_o = PTR_HI_THRESH; end
            5'd7:  begin op_o = OP_W; byte_o = 8'h80; end
            5'd11: begin op_o = OP_W; byte_o = PTR_CONFIG; end
            5'd12: begin op_o = OP_W; byte_o = CONFIG[15:8]; end
            5'd13: begin op_o = OP_W; byte_o = CONFIG[7:0]; end
            5'd16: begin op_o = OP_W; byte_o = PTR_CONV; end
            5'd2, 5'd3, 5'd8: op_o = OP_W;
            5'd17: op_o = OP_START_R;
            5'd18: op_o = OP_R_ACK;
            5'd19: op_o = OP_R_NACK;
            default: op_o = OP_STOP;
        endcase
    end

endmodule

// File: rtl/ads1115_ctrl.sv
// ads1115_ctrl: configures an ADS1115 over an i2c_master command port, then reads
// one conversion per ALERT/RDY falling edge and presents it as a one-cycle sample.
module ads1115_ctrl
    import ads1115_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR   = 7'h48,
    parameter logic [15:0] CONFIG     = 16'hC284,
    parameter int          RETRY_CLKS = 250000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_alert_n,
    output logic [15:0] o_sample,
    output logic        o_sample_valid,
    output logic        o_configured,
    output logic        o_error,
    output logic        o_overrun,
    output logic [6:0]  o_m_addr,
    output logic        o_m_rw,
    output logic        o_m_start,
    output logic [7:0]  o_m_wdata,
    output logic        o_m_wvalid,
    output logic        o_m_rready,
    output logic        o_m_stop,
    output logic        o_m_ack_send,
    input  logic [7:0]  i_m_rdata,
    input  logic        i_m_rvalid,
    input  logic        i_m_ack_recv,
    input  logic        i_m_done
);

    localparam int CW = $clog2(RETRY_CLKS + 1);

    state_e        state_q, state_d;
    logic [4:0]    step_q, step_d;
    logic          pending_q, pending_d;
    logic          configured_q, configured_d;
    logic [15:0]   sample_q, sample_d;
    logic          sample_valid_q, sample_valid_d;
    logic          error_q, error_d;
    logic          overrun_q, overrun_d;
    logic          ack_send_q, ack_send_d;
    logic [7:0]    msb_q, msb_d, lsb_q, lsb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    alert_q;
    op_e           op;
    logic [7:0]    op_byte;
    logic          issue, alert_fall;

    ads1115_op_rom #(.CONFIG(CONFIG)) u_rom (
        .step_i (step_q),
        .op_o   (op),
        .byte_o (op_byte)
    );

    assign issue      = state_q == S_ISSUE;
    assign alert_fall = alert_q[2] & ~alert_q[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= S_IDLE;
            step_q         <= '0;
            pending_q      <= 1'b0;
            configured_q   <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            error_q        <= 1'b0;
            overrun_q      <= 1'b0;
            ack_send_q     <= 1'b1;
            msb_q          <= '0;
            lsb_q          <= '0;
            cnt_q          <= '0;
            alert_q        <= 3'b111;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            pending_q      <= pending_d;
            configured_q   <= configured_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            error_q        <= error_d;
            overrun_q      <= overrun_d;
            ack_send_q     <= ack_send_d;
            msb_q          <= msb_d;
            lsb_q          <= lsb_d;
            cnt_q          <= cnt_d;
            alert_q        <= {alert_q[1:0], i_alert_n};
        end
    end

    always_comb begin
        state_d        = state_q;
        step_d         = step_q;
        pending_d      = pending_q;
        configured_d   = configured_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        error_d        = 1'b0;
        overrun_d      = 1'b0;
        msb_d          = msb_q;
        lsb_d          = lsb_q;
        cnt_d          = cnt_q;
        ack_send_d     = issue && op == OP_R_ACK  ? 1'b0 :
                         issue && op == OP_R_NACK ? 1'b1 : ack_send_q;
        if (alert_fall && configured_q) begin
            pending_d = 1'b1;
            overrun_d = pending_q;
        end
        case (state_q)
            S_IDLE: if (i_enable) begin
                step_d  = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (i_m_rvalid && op == OP_R_ACK) msb_d = i_m_rdata;
                if (i_m_rvalid && op == OP_R_NACK) lsb_d = i_m_rdata;
                if (i_m_done) begin
                    if (expects_ack(op) && i_m_ack_recv) begin
                        state_d = S_NACK;
                    end else if (op == OP_STOP && step_q == STEP_CFG_LAST) begin
                        configured_d = 1'b1;
                        state_d      = S_ARMED;
                    end else if (op == OP_STOP && step_q == STEP_RD_LAST) begin
                        sample_d       = {msb_q, lsb_q};
                        sample_valid_d = 1'b1;
                        state_d        = S_ARMED;
                    end else begin
                        step_d  = step_q + 5'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ARMED: begin
                if (!i_enable) begin
                    configured_d = 1'b0;
                    state_d      = S_IDLE;
                end else if (pending_q) begin
                    // A fresh edge in this cycle re-arms without counting as overrun.
                    pending_d = alert_fall;
                    overrun_d = 1'b0;
                    step_d    = STEP_RD_FIRST;
                    state_d   = S_ISSUE;
                end
            end
            S_NACK: state_d = S_NACK_WAIT;
            S_NACK_WAIT: if (i_m_done) begin
                error_d      = 1'b1;
                configured_d = 1'b0;
                pending_d    = 1'b0;
                cnt_d        = '0;
                state_d      = S_RETRY;
            end
            S_RETRY: begin
                if (cnt_q == CW'(RETRY_CLKS - 1)) state_d = S_IDLE;
                else cnt_d = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_m_addr       = DEV_ADDR;
    assign o_m_start      = issue && (op == OP_START_W || op == OP_START_R);
    assign o_m_rw         = issue && op == OP_START_R;
    assign o_m_wvalid     = issue && op == OP_W;
    assign o_m_wdata      = o_m_wvalid ? op_byte : 8'h00;
    assign o_m_rready     = issue && (op == OP_R_ACK || op == OP_R_NACK);
    assign o_m_stop       = (issue && op == OP_STOP) || state_q == S_NACK;
    assign o_m_ack_send   = ack_send_d;
    assign o_sample       = sample_q;
    assign o_sample_valid = sample_valid_q;
    assign o_configured   = configured_q;
    assign o_error        = error_q;
    assign o_overrun      = overrun_q;

endmodule

// File: tb/tb_ads1115_ctrl.sv
// tb_ads1115_ctrl: randomized-latency I2C master model plus an op-list reference
// of the ADS1115 programming and read transactions.
module tb_ads1115_ctrl;

    localparam int RETRY = 100;
    localparam int K_SW = 0, K_SR = 1, K_W = 2, K_RD = 3, K_STOP = 4;

    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, alert_n = 1'b1;
    logic [15:0] o_sample;
    logic        o_sample_valid, o_configured, o_error, o_overrun;
    logic [6:0]  o_m_addr;
    logic        o_m_rw, o_m_start, o_m_wvalid, o_m_rready, o_m_stop, o_m_ack_send;
    logic [7:0]  o_m_wdata;
    logic [7:0]  m_rdata = 8'h00;
    logic        m_rvalid = 1'b0, m_ack = 1'b0, m_done = 1'b0;

    typedef struct {int kind; int data; int t;} cmd_t;
    cmd_t        log_q[$];
    logic [7:0]  rd_q[$];
    int          n_chk = 0, n_pass = 0, cyc = 0, multi = 0;
    int          n_valid = 0, n_err = 0, n_ovr = 0;
    int          nack_idx = -1, lat_min = 1, lat_max = 4;
    logic [15:0] last_sample = 16'h0;

    ads1115_ctrl #(.RETRY_CLKS(RETRY)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_alert_n(alert_n),
        .o_sample(o_sample), .o_sample_valid(o_sample_valid), .o_configured(o_configured),
        .o_error(o_error), .o_overrun(o_overrun), .o_m_addr(o_m_addr), .o_m_rw(o_m_rw),
        .o_m_start(o_m_start), .o_m_wdata(o_m_wdata), .o_m_wvalid(o_m_wvalid),
        .o_m_rready(o_m_rready), .o_m_stop(o_m_stop), .o_m_ack_send(o_m_ack_send),
        .i_m_rdata(m_rdata), .i_m_rvalid(m_rvalid), .i_m_ack_recv(m_ack), .i_m_done(m_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_sample_valid) begin
            n_valid     <= n_valid + 1;
            last_sample <= o_sample;
        end
        if (o_error) n_err <= n_err + 1;
        if (o_overrun) n_ovr <= n_ovr + 1;
    end

    // I2C master model: logs each command, completes it after a random latency.
    initial begin
        cmd_t e;
        int   n, lat;
        logic nack, rd;
        forever begin
            @(negedge clk);
            m_done = 1'b0; m_rvalid = 1'b0; m_ack = 1'b0;
            n = int'(o_m_start) + int'(o_m_wvalid) + int'(o_m_rready) + int'(o_m_stop);
            if (n > 1) multi++;
            if (n != 0 && !rst) begin
                e.kind = o_m_start ? (o_m_rw ? K_SR : K_SW) : o_m_wvalid ? K_W :
                         o_m_rready ? K_RD : K_STOP;
                e.data = o_m_wvalid ? int'(o_m_wdata) : o_m_rready ? int'(o_m_ack_send) : 0;
                e.t    = cyc;
                log_q.push_back(e);
                nack = (log_q.size() - 1 == nack_idx) && e.kind != K_STOP && e.kind != K_RD;
                rd   = o_m_rready;
                lat  = $urandom_range(lat_max, lat_min);
                repeat (lat) @(negedge clk);
                m_done = 1'b1;
                m_ack  = nack;
                if (rd) begin
                    m_rvalid = 1'b1;
                    m_rdata  = rd_q.size() != 0 ? rd_q.pop_front() : 8'($urandom);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cmp_seq(input string tag, input int base, input int ek[$], input int ed[$]);
        for (int i = 0; i < ek.size(); i++) begin
            if (base + i < log_q.size())
                chk($sformatf("%s[%0d]", tag, i),
                    log_q[base+i].kind * 256 + log_q[base+i].data, ek[i] * 256 + ed[i]);
            else
                chk($sformatf("%s[%0d] missing", tag, i), 0, 1);
        end
    endtask

    task automatic check_cfg(input string tag, input int base);
        int          ek[$], ed[$];
        logic [7:0]  ptr[3] = '{8'h02, 8'h03, 8'h01};
        logic [15:0] val[3] = '{16'h0000, 16'h8000, 16'hC284};
        for (int r = 0; r < 3; r++) begin
            ek.push_back(K_SW);   ed.push_back(0);
            ek.push_back(K_W);    ed.push_back(int'(ptr[r]));
            ek.push_back(K_W);    ed.push_back(int'(val[r][15:8]));
            ek.push_back(K_W);    ed.push_back(int'(val[r][7:0]));
            ek.push_back(K_STOP); ed.push_back(0);
        end
        cmp_seq(tag, base, ek, ed);
    endtask

    task automatic check_read(input string tag, input int base);
        cmp_seq(tag, base, '{K_SW, K_W, K_SR, K_RD, K_RD, K_STOP}, '{0, 0, 0, 0, 1, 0});
    endtask

    task automatic wait_cfg(input logic lvl, input int budget);
        int b = budget;
        while (o_configured !== lvl && b > 0) begin @(negedge clk); #1; b--; end
    endtask

    task automatic wait_valid(input int target, input int budget);
        int b = budget;
        while (n_valid < target && b > 0) begin @(negedge clk); #1; b--; end
    endtask

    task automatic wait_log(input int target, input int budget);
        int b = budget;
        while (log_q.size() < target && b > 0) begin @(negedge clk); #1; b--; end
    endtask

    task automatic pulse(input int low);
        alert_n = 1'b0;
        repeat (low) @(negedge clk);
        alert_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
    endtask

    initial begin
        int          base, v0, o0, e0, b, t_err, gap;
        logic [7:0]  by[4];
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sample", o_sample, 0);
        chk("rst_valid", o_sample_valid, 0);
        chk("rst_configured", o_configured, 0);
        chk("rst_error", o_error, 0);
        chk("rst_overrun", o_overrun, 0);
        chk("rst_ack_send", o_m_ack_send, 1);
        chk("rst_addr", o_m_addr, 7'h48);
        chk("rst_cmds", {o_m_start, o_m_rw, o_m_wvalid, o_m_rready, o_m_stop, o_m_wdata}, 0);
        rst = 1'b0;

        enable = 1'b1;
        wait_cfg(1'b1, 3000);
        chk("cfg_done", o_configured, 1);
        chk("cfg_len", log_q.size(), 15);
        check_cfg("cfg", 0);

        base = log_q.size(); v0 = n_valid;
        rd_q.push_back(8'h12); rd_q.push_back(8'h34);
        pulse(200);
        wait_valid(v0 + 1, 2000);
        repeat (20) @(negedge clk);
        #1;
        chk("rd1234_valid_cnt", n_valid, v0 + 1);
        chk("rd1234_sample", last_sample, 16'h1234);
        chk("rd1234_len", log_q.size(), base + 6);
        check_read("rd1234", base);

        for (int i = 0; i < 4; i++) begin
            base = log_q.size(); v0 = n_valid;
            by[0] = 8'($urandom); by[1] = 8'($urandom);
            rd_q.push_back(by[0]); rd_q.push_back(by[1]);
            pulse(3);
            wait_valid(v0 + 1, 2000);
            chk($sformatf("rnd%0d_sample", i), last_sample, {by[0], by[1]});
            chk($sformatf("rnd%0d_len", i), log_q.size(), base + 6);
        end

        lat_min = 8; lat_max = 10;
        base = log_q.size(); v0 = n_valid; o0 = n_ovr;
        for (int i = 0; i < 4; i++) begin by[i] = 8'($urandom); rd_q.push_back(by[i]); end
        pulse(3);
        wait_log(base + 1, 200);
        pulse(3);
        pulse(3);
        wait_valid(v0 + 2, 3000);
        repeat (100) @(negedge clk);
        #1;
        chk("ovr_pulses", n_ovr, o0 + 1);
        chk("ovr_valid_cnt", n_valid, v0 + 2);
        chk("ovr_len", log_q.size(), base + 12);
        chk("ovr_sample", last_sample, {by[2], by[3]});
        check_read("ovr_rd0", base);
        check_read("ovr_rd1", base + 6);

        lat_min = 1; lat_max = 4;
        enable = 1'b0;
        wait_cfg(1'b0, 50);
        base = log_q.size(); e0 = n_err;
        nack_idx = base + 5;
        enable = 1'b1;
        b = 2000;
        while (n_err == e0 && b > 0) begin @(negedge clk); #1; b--; end
        t_err = cyc;
        nack_idx = -1;
        chk("nack_err_cnt", n_err, e0 + 1);
        chk("nack_configured", o_configured, 0);
        chk("nack_len", log_q.size(), base + 7);
        if (log_q.size() >= base + 7) begin
            chk("nack_step5", log_q[base+5].kind, K_SW);
            chk("nack_stop", log_q[base+6].kind, K_STOP);
        end
        wait_log(base + 8, RETRY + 200);
        gap = log_q.size() >= base + 8 ? log_q[base+7].t - t_err : 0;
        chk("retry_gap", gap >= RETRY + 1 && gap <= RETRY + 3, 1);
        wait_cfg(1'b1, 3000);
        chk("retry_cfg", o_configured, 1);
        check_cfg("recfg", base + 7);

        enable = 1'b0;
        wait_cfg(1'b0, 50);
        lat_min = 4; lat_max = 6;
        base = log_q.size(); v0 = n_valid; o0 = n_ovr;
        enable = 1'b1;
        repeat (5) @(negedge clk);
        pulse(3);
        chk("early_unconfigured", o_configured, 0);
        wait_cfg(1'b1, 3000);
        repeat (100) @(negedge clk);
        #1;
        chk("early_len", log_q.size(), base + 15);
        chk("early_ovr", n_ovr, o0);
        chk("early_valid", n_valid, v0);

        lat_min = 3; lat_max = 5;
        base = log_q.size();
        pulse(3);
        wait_log(base + 4, 300);
        chk("rst_mid_rack", log_q.size() >= base + 4 ? log_q[base+3].kind * 256 + log_q[base+3].data : -1,
            K_RD * 256);
        @(negedge clk);
        #1;
        enable = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_cmds", {o_m_start, o_m_rw, o_m_wvalid, o_m_rready, o_m_stop, o_m_wdata}, 0);
        chk("rst_mid_valid", o_sample_valid, 0);
        chk("rst_mid_configured", o_configured, 0);
        chk("rst_mid_ack_send", o_m_ack_send, 1);
        pulse(3);
        repeat (300) @(negedge clk);
        #1;
        chk("rst_mid_quiet", log_q.size(), base + 4);
        chk("one_cmd_per_issue", multi, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
